addsub_serial_acc: RTL

ADDSUB_SERIAL_ACC -- requirements
Module: addsub_serial_acc

---
 rtl/addsub_serial_acc.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/addsub_serial_acc.sv
// ---------------------------------------------------------------------------
// addsub_serial_acc
//   Digit-serial two's-complement adder/subtractor with an accumulate mode.
//   One DIGIT-bit slice is added per cycle, LSB slice first. The slice carry
//   is registered between cycles, so a WIDTH-bit operation takes K = WIDTH/DIGIT
//   RUN cycles. After that comes a single DONE cycle that pulses done_o.
//   Optional signed saturation is controlled by SATURATE.
//
//   Parameters
//     WIDTH    operand/result width (must be a multiple of DIGIT)
//     DIGIT    bits added per cycle
//     SATURATE 1 = clamp the result on signed overflow
//
//   Ports
//     clk_i         clock, rising edge
//     rst_ni        asynchronous active-low reset
//     start_i       launch an operation (sampled in IDLE or DONE only)
//     op_i          00 A+B, 01 A-B, 10 S+B, 11 S-B
//     a_i, b_i      operands
//     clr_sticky_i  clear sticky_ovf_o (loses to a same-edge set)
//     busy_o        high in every RUN cycle
//     done_o        one-cycle pulse, result valid
//     s_o           registered result, held until the next done
//     overflow_o    signed overflow of the last operation
//     carry_o       carry out of the MSB (subtract: 1 = no borrow)
//     sticky_ovf_o  set by any overflowing operation until cleared
// ---------------------------------------------------------------------------
module addsub_serial_acc #(
  parameter int WIDTH    = 16,
  parameter int DIGIT    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clr_sticky_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             overflow_o,
  output logic             carry_o,
  output logic             sticky_ovf_o
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  opa_q, opa_d;     // first operand, shifted right per slice
  logic [WIDTH-1:0]  opb_q, opb_d;     // second operand (already inverted for subtract)
  logic [WIDTH-1:0]  res_q, res_d;     // partial sum, filled one slice at a time
  logic              cy_q, cy_d;       // inter-slice carry
  logic [WIDTH-1:0]  s_q, s_d;
  logic              ovf_q, ovf_d;
  logic              carry_q, carry_d;
  logic              sticky_q, sticky_d;

  // Slice datapath
  logic [DIGIT-1:0]  slice_a, slice_b;
  logic [DIGIT:0]    slice_sum;
  logic              cin_msb;
  logic              last;
  logic              ovf_now;
  logic [WIDTH-1:0]  sat_val;

  assign slice_a   = opa_q[DIGIT-1:0];
  assign slice_b   = opb_q[DIGIT-1:0];
  assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, cy_q};

  // On the final slice, bit DIGIT-1 is the word MSB. The carry into it is
  // recovered from the sum bit, so this also works when DIGIT == 1.
  assign cin_msb = slice_sum[DIGIT-1] ^ slice_a[DIGIT-1] ^ slice_b[DIGIT-1];
  assign last    = (cnt_q == CW'(K - 1));
  assign ovf_now = cin_msb ^ slice_sum[DIGIT];

  // Overflow needs same-signed operands, so the first operand's sign
  // decides which rail to clamp to.
  assign sat_val = slice_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    cy_d     = cy_q;
    s_d      = s_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    sticky_d = sticky_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
          // Accumulate ops read s_q as it stands now, including a clamped value.
          opa_d   = op_i[1] ? s_q : a_i;
          opb_d   = op_i[0] ? ~b_i : b_i;
          cy_d    = op_i[0];
          res_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d[int'(cnt_q)*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
        cy_d  = slice_sum[DIGIT];
        opa_d = opa_q >> DIGIT;
        opb_d = opb_q >> DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          ovf_d   = ovf_now;
          carry_d = slice_sum[DIGIT];
          s_d     = ((SATURATE != 0) && ovf_now) ? sat_val : res_d;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set takes priority over clear on the same edge.
    if (clr_sticky_i) sticky_d = 1'b0;
    if ((state_q == RUN) && last && ovf_now) sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      cy_q     <= 1'b0;
      s_q      <= '0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      cy_q     <= cy_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
      sticky_q <= sticky_d;
    end
  end

  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign s_o          = s_q;
  assign overflow_o   = ovf_q;
  assign carry_o      = carry_q;
  assign sticky_ovf_o = sticky_q;

`ifndef SYNTHESIS
  // Every RUN phase is at least one cycle long, so done can never repeat.
  a_busy_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(busy_o && done_o));
  a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_o |=> !done_o);
`endif

endmodule
